// File: rtl/expu_pkg.sv
// Shared EXPU definitions: floating-point format parameters, the log2(e)
// constant, fixed-point width helpers and the operand class enum.
// No ports; imported by expu_schraudolph and expu_fp2fixed.
package expu_pkg;

  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} exp_class_e;

  function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned fp_man_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 7;
    endcase
  endfunction

  function automatic int unsigned fp_width(input fp_format_e fmt);
    return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
  endfunction

  function automatic int unsigned fp_bias(input fp_format_e fmt);
    return (1 << (fp_exp_bits(fmt) - 1)) - 1;
  endfunction

  // int(1.4427 * 2^frac), computed in integers to stay synthesizable
  function automatic int unsigned log2e_const(input int unsigned frac);
    return int'((64'd14427 << frac) / 64'd10000);
  endfunction

  localparam int unsigned LOG2E = log2e_const(10);

  // Unsigned product width, Q2.(man+frac)
  function automatic int unsigned p_width(input int unsigned man, input int unsigned lf);
    return man + lf + 2;
  endfunction

  // Signed fixed-point y width, Q(int_bits+1).(man+frac)
  function automatic int unsigned f_width(input int unsigned int_bits, input int unsigned man,
                                          input int unsigned lf);
    return int_bits + 1 + man + lf;
  endfunction

endpackage

// File: rtl/expu_fp2fixed.sv
// Combinational conversion of the scaled mantissa product P (Q2.FRAC) and
// unbiased exponent E into signed fixed-point y = +-P*2^E.
// Ports: p (product), e (signed unbiased exponent), sign (operand sign),
//        f (signed Q(INT_BITS+1).FRAC result), ovf (|y| too large to represent).
module expu_fp2fixed
  import expu_pkg::*;
#(
  parameter int unsigned MANT_BITS      = 7,
  parameter int unsigned LOG2E_FRACTION = 10,
  parameter int unsigned INT_BITS       = 8,
  parameter int unsigned EXP_W          = 9
) (
  input  logic [p_width(MANT_BITS, LOG2E_FRACTION)-1:0]                  p,
  input  logic signed [EXP_W-1:0]                                        e,
  input  logic                                                           sign,
  output logic signed [f_width(INT_BITS, MANT_BITS, LOG2E_FRACTION)-1:0] f,
  output logic                                                           ovf
);

  localparam int unsigned FRAC = MANT_BITS + LOG2E_FRACTION;
  localparam int unsigned FW   = f_width(INT_BITS, MANT_BITS, LOG2E_FRACTION);
  localparam int          OVF_E = int'(INT_BITS) - 1;
  localparam int          MIN_E = -int'(FRAC + 2);

  logic [FW-1:0] mag;

  // Saturating shift; P < 4 so E <= INT_BITS-2 always fits the integer field
  always_comb begin
    mag = '0;
    ovf = 1'b0;
    if (int'(e) >= OVF_E) begin
      ovf = 1'b1;
    end else if (int'(e) < MIN_E) begin
      mag = '0;
    end else if (int'(e) >= 0) begin
      mag = FW'(p) << unsigned'(e);
    end else begin
      mag = FW'(p) >> unsigned'(EXP_W'(-e));
    end
  end

  assign f = sign ? -$signed(mag) : $signed(mag);

endmodule

// File: rtl/expu_schraudolph.sv
// Two-stage elastic Schraudolph exp(x) approximation: y = x*log2(e) in fixed
// point, floor(y) becomes the biased exponent and frac(y) the raw mantissa.
// Ports: clk_i, rst_i (sync, active-high), valid_i/ready_o/op_i (input side),
//        valid_o/ready_i/res_o (result side, res_o = {0, exp, mant}).
// Build option: EXPU_SCHRAUDOLPH_ROUND_EN rounds the mantissa to nearest
// (ties up) instead of truncating.
module expu_schraudolph
  import expu_pkg::*;
#(
  parameter fp_format_e  FPFORMAT       = FP16ALT,
  parameter int unsigned LOG2E_FRACTION = 10,
  parameter int unsigned INT_BITS       = fp_exp_bits(FPFORMAT)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [fp_width(FPFORMAT)-1:0] op_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [fp_width(FPFORMAT)-1:0] res_o
);

  localparam int unsigned WIDTH = fp_width(FPFORMAT);
  localparam int unsigned EB    = fp_exp_bits(FPFORMAT);
  localparam int unsigned MB    = fp_man_bits(FPFORMAT);
  localparam int unsigned BIAS  = fp_bias(FPFORMAT);
  localparam int unsigned LOG2E_C = log2e_const(LOG2E_FRACTION);
  localparam int unsigned FRAC  = MB + LOG2E_FRACTION;
  localparam int unsigned PW    = p_width(MB, LOG2E_FRACTION);
  localparam int unsigned FW    = f_width(INT_BITS, MB, LOG2E_FRACTION);
  localparam int unsigned EW    = EB + 1;
  localparam int unsigned EVW   = ((INT_BITS > EB) ? INT_BITS : EB) + 3;
  localparam logic signed [EVW-1:0] EV_BIAS = EVW'(BIAS);
  localparam logic signed [EVW-1:0] EV_MAX  = EVW'((1 << EB) - 1);

  localparam logic [WIDTH-1:0] RES_NAN  = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
  localparam logic [WIDTH-1:0] RES_INF  = {1'b0, {EB{1'b1}}, {MB{1'b0}}};
  localparam logic [WIDTH-1:0] RES_ZERO = '0;
  localparam logic [WIDTH-1:0] RES_ONE  = {1'b0, EB'(BIAS), {MB{1'b0}}};

  // Handshake
  logic v1, v2, en1, en2;
  assign en2     = ready_i | ~v2;
  assign en1     = ~v1 | en2;
  assign ready_o = en1;
  assign valid_o = v2;

  // Stage 1: classify operand and scale mantissa by log2(e)
  logic               op_sign;
  logic [EB-1:0]      op_exp;
  logic [MB-1:0]      op_man;
  exp_class_e         cls_d, cls_q;
  logic [PW-1:0]      p_d, p_q;
  logic signed [EW-1:0] e_d, e_q;
  logic               s_q;

  assign op_sign = op_i[WIDTH-1];
  assign op_exp  = op_i[WIDTH-2 -: EB];
  assign op_man  = op_i[MB-1:0];
  assign p_d     = PW'({1'b1, op_man}) * PW'(LOG2E_C);
  assign e_d     = $signed(EW'(op_exp)) - $signed(EW'(BIAS));

  always_comb begin
    cls_d = NORMAL;
    if (op_exp == '0)               cls_d = ZERO;
    else if (op_exp == {EB{1'b1}})  cls_d = (op_man == '0) ? INF : NAN;
  end

  // Stage 2: fixed-point y, exponent/mantissa split, special-case selection
  logic signed [FW-1:0]  f;
  logic                  ovf;
  logic signed [EVW-1:0] ev;
  logic [MB-1:0]         mant;
  logic [WIDTH-1:0]      res_d;

  expu_fp2fixed #(
    .MANT_BITS     (MB),
    .LOG2E_FRACTION(LOG2E_FRACTION),
    .INT_BITS      (INT_BITS),
    .EXP_W         (EW)
  ) u_fp2fixed (
    .p   (p_q),
    .e   (e_q),
    .sign(s_q),
    .f   (f),
    .ovf (ovf)
  );

`ifdef EXPU_SCHRAUDOLPH_ROUND_EN
  // Round half up on the first discarded fraction bit; carry bumps exponent
  logic          man_carry;
  logic [MB-1:0] man_rnd;
  assign {man_carry, man_rnd} = {1'b0, f[FRAC-1 -: MB]} + (MB+1)'(f[FRAC-MB-1]);
  assign ev   = EVW'(f >>> FRAC) + EV_BIAS + $signed({{(EVW-1){1'b0}}, man_carry});
  assign mant = man_rnd;
`else
  assign ev   = EVW'(f >>> FRAC) + EV_BIAS;
  assign mant = f[FRAC-1 -: MB];
`endif

  always_comb begin
    res_d = {1'b0, ev[EB-1:0], mant};
    if (cls_q == NAN)                              res_d = RES_NAN;
    else if ((cls_q == INF || ovf) && !s_q)        res_d = RES_INF;
    else if ((cls_q == INF || ovf) && s_q)         res_d = RES_ZERO;
    else if (ev >= EV_MAX)                         res_d = RES_INF;
    else if (ev[EVW-1] || ev == '0)                res_d = RES_ZERO;
    else if (cls_q == ZERO)                        res_d = RES_ONE;
  end

  // Pipeline registers; data holds whenever its stage is not advancing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      res_o <= '0;
      p_q   <= '0;
      e_q   <= '0;
      s_q   <= 1'b0;
      cls_q <= ZERO;
    end else begin
      if (en1) begin
        v1 <= valid_i;
        if (valid_i) begin
          p_q   <= p_d;
          e_q   <= e_d;
          s_q   <= op_sign;
          cls_q <= cls_d;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) res_o <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_expu_schraudolph.sv
// Directed self-checking bench for expu_schraudolph (FP16ALT defaults).
module tb_expu_schraudolph;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] op_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  expu_schraudolph dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .op_i   (op_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .res_o  (res_o)
  );

`ifdef EXPU_SCHRAUDOLPH_ROUND_EN
  localparam logic [15:0] ONE_RES = 16'h4039;
`else
  localparam logic [15:0] ONE_RES = 16'h4038;
`endif

  // op -> expected (hand-computed from P = {1,mant}*1477, F = P<<E)
  logic [15:0] dir_op  [13] = '{16'h0000, 16'h3F80, 16'hBF80, 16'h4000, 16'h3F00,
                                16'h42C8, 16'hC2C8, 16'h7FC0, 16'hFF80, 16'h7F80,
                                16'h0001, 16'h4300, 16'hC300};
  logic [15:0] dir_exp [13] = '{16'h3F80, ONE_RES,  16'h3EC7, 16'h40F1, 16'h3FDC,
                                16'h7F80, 16'h0000, 16'h7FC0, 16'h0000, 16'h7F80,
                                16'h3F80, 16'h7F80, 16'h0000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_one(input int idx);
    int n;
    @(negedge clk);
    check($sformatf("rdy%0d", idx), 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    op_i    = dir_op[idx];
    @(negedge clk);
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("lat%0d", idx), 32'(n), 32'd2);
    check($sformatf("res%0d_op%h", idx, dir_op[idx]), 32'(res_o), 32'(dir_exp[idx]));
  endtask

  int          in_i, out_i, cyc;
  logic        stall_prev;
  logic [15:0] held;

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res",   32'(res_o),   32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);

    for (int i = 0; i < 13; i++) send_one(i);

    // Stream of 8 with a 3-cycle downstream stall
    in_i = 0; out_i = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (out_i < 8 && cyc < 60) begin
      @(negedge clk);
      ready_i = !(cyc >= 4 && cyc < 7);
      valid_i = (in_i < 8);
      op_i    = (in_i < 8) ? dir_op[in_i] : 16'h0;
      #1;
      if (stall_prev) check("hold", 32'(res_o), 32'(held));
      if (valid_o && ready_i) begin
        check($sformatf("stream%0d", out_i), 32'(res_o), 32'(dir_exp[out_i]));
        out_i++;
      end
      stall_prev = valid_o && !ready_i;
      held       = res_o;
      if (valid_i && ready_o) in_i++;
      cyc++;
    end
    check("stream_count", 32'(out_i), 32'd8);
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_dup", 32'(valid_o), 32'd0);
    end

    // Fill both stages, then reset
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      op_i    = dir_op[1 + i];
    end
    @(negedge clk);
    valid_i = 1'b0;
    check("full_valid", 32'(valid_o), 32'd1);
    check("full_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst2_valid", 32'(valid_o), 32'd0);
    check("rst2_res",   32'(res_o),   32'd0);
    check("rst2_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst2_drop", 32'(valid_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
